// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the pipelined IEEE-754 multiplier.
package fp_mul_pkg;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Built 64 bits wide so any supported format can slice off its own width.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

    function automatic logic [63:0] max_finite(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd2) << man_w;
        r = r | ((64'd1 << man_w) - 64'd1);
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_norm_round.sv
// Final multiplier stage: normalise, round, range-check and pack the product.
module fp_mul_norm_round
    import fp_mul_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W,
    localparam int EW    = EXP_W + 2,
    localparam int PW    = 2 * MAN_W + 2
) (
    input  logic                 sign,
    input  fp_class_e            cls_a,
    input  fp_class_e            cls_b,
    input  logic signed [EW-1:0] exp_sum,
    input  logic [PW-1:0]        prod,
    input  logic                 rnd_mode,
    output logic [W-1:0]         result,
    output logic [3:0]           flags
);
    localparam logic [63:0]          NAN_FULL = canon_nan(EXP_W, MAN_W);
    localparam logic [63:0]          MAX_FULL = max_finite(EXP_W, MAN_W);
    localparam logic signed [EW-1:0] E_MAX    = EW'(2**EXP_W - 1);
    localparam logic signed [EW-1:0] E_ZERO   = '0;

    logic [PW-1:0]        norm;
    logic [MAN_W-1:0]     frac;
    logic                 guard;
    logic                 sticky;
    logic                 inc;
    logic                 invalid;
    logic [MAN_W:0]       frac_rnd;
    logic signed [EW-1:0] exp_adj;
    logic [W-1:0]         inf_val;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4); shift so the leading one sits at the MSB.
        norm     = prod[PW-1] ? prod : (prod << 1);
        frac     = norm[PW-2:MAN_W+1];
        guard    = norm[MAN_W];
        sticky   = |norm[MAN_W-1:0];
        inc      = rnd_mode && guard && (sticky || frac[0]);
        frac_rnd = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
        exp_adj  = exp_sum + EW'(prod[PW-1]) + EW'(frac_rnd[MAN_W]);
        invalid  = (cls_a == FP_INF && cls_b == FP_ZERO) || (cls_a == FP_ZERO && cls_b == FP_INF);
        inf_val  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

        result = '0;
        flags  = '0;
        if (cls_a == FP_NAN || cls_b == FP_NAN || invalid) begin
            result              = NAN_FULL[W-1:0];
            flags[FLAG_INVALID] = invalid;
        end else if (cls_a == FP_INF || cls_b == FP_INF) begin
            result = inf_val;
        end else if (cls_a == FP_ZERO || cls_b == FP_ZERO) begin
            result = {sign, {(W-1){1'b0}}};
        end else if (exp_adj >= E_MAX) begin
            result               = rnd_mode ? inf_val : {sign, MAX_FULL[W-2:0]};
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INEXACT]  = 1'b1;
        end else if (exp_adj <= E_ZERO) begin
            result                = {sign, {(W-1){1'b0}}};
            flags[FLAG_UNDERFLOW] = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end else begin
            result              = {sign, exp_adj[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
            flags[FLAG_INEXACT] = guard | sticky;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier with valid/ready flow control on both sides.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         rnd_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);
    localparam int            EW   = EXP_W + 2;
    localparam int            PW   = 2 * MAN_W + 2;
    localparam int            SW   = MAN_W + 1;
    localparam logic [EW-1:0] BIAS = EW'(2**(EXP_W-1) - 1);

    logic adv;
    fp_class_e cls_a, cls_b;

    logic                 s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_rnd_q, s1_rnd_d;
    fp_class_e            s1_cls_a_q, s1_cls_a_d, s1_cls_b_q, s1_cls_b_d;
    logic signed [EW-1:0] s1_exp_q, s1_exp_d;
    logic [SW-1:0]        s1_sig_a_q, s1_sig_a_d, s1_sig_b_q, s1_sig_b_d;

    logic                 s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_rnd_q, s2_rnd_d;
    fp_class_e            s2_cls_a_q, s2_cls_a_d, s2_cls_b_q, s2_cls_b_d;
    logic signed [EW-1:0] s2_exp_q, s2_exp_d;
    logic [PW-1:0]        s2_prod_q, s2_prod_d;

    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         result_q, result_d, nr_result;
    logic [3:0]           flags_q, flags_d, nr_flags;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0)
            return FP_ZERO;
        else if (&e)
            return (f == '0) ? FP_INF : FP_NAN;
        else
            return FP_NORM;
    endfunction

    // Whole pipeline moves as one unit, gated only by the output register being free.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        cls_a = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
        cls_b = classify(b[W-2:MAN_W], b[MAN_W-1:0]);

        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_rnd_d   = s1_rnd_q;
        s1_cls_a_d = s1_cls_a_q;
        s1_cls_b_d = s1_cls_b_q;
        s1_exp_d   = s1_exp_q;
        s1_sig_a_d = s1_sig_a_q;
        s1_sig_b_d = s1_sig_b_q;
        if (adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d  = a[W-1] ^ b[W-1];
                s1_rnd_d   = rnd_mode;
                s1_cls_a_d = cls_a;
                s1_cls_b_d = cls_b;
                s1_exp_d   = EW'(a[W-2:MAN_W]) + EW'(b[W-2:MAN_W]) - BIAS;
                s1_sig_a_d = {cls_a == FP_NORM, a[MAN_W-1:0]};
                s1_sig_b_d = {cls_b == FP_NORM, b[MAN_W-1:0]};
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_rnd_d   = s2_rnd_q;
        s2_cls_a_d = s2_cls_a_q;
        s2_cls_b_d = s2_cls_b_q;
        s2_exp_d   = s2_exp_q;
        s2_prod_d  = s2_prod_q;
        if (adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_d  = s1_sign_q;
                s2_rnd_d   = s1_rnd_q;
                s2_cls_a_d = s1_cls_a_q;
                s2_cls_b_d = s1_cls_b_q;
                s2_exp_d   = s1_exp_q;
                s2_prod_d  = PW'(s1_sig_a_q) * PW'(s1_sig_b_q);
            end
        end
    end

    fp_mul_norm_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm_round (
        .sign     (s2_sign_q),
        .cls_a    (s2_cls_a_q),
        .cls_b    (s2_cls_b_q),
        .exp_sum  (s2_exp_q),
        .prod     (s2_prod_q),
        .rnd_mode (s2_rnd_q),
        .result   (nr_result),
        .flags    (nr_flags)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (adv) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                result_d = nr_result;
                flags_d  = nr_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_rnd_q    <= 1'b0;
            s1_cls_a_q  <= FP_ZERO;
            s1_cls_b_q  <= FP_ZERO;
            s1_exp_q    <= '0;
            s1_sig_a_q  <= '0;
            s1_sig_b_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_rnd_q    <= 1'b0;
            s2_cls_a_q  <= FP_ZERO;
            s2_cls_b_q  <= FP_ZERO;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_rnd_q    <= s1_rnd_d;
            s1_cls_a_q  <= s1_cls_a_d;
            s1_cls_b_q  <= s1_cls_b_d;
            s1_exp_q    <= s1_exp_d;
            s1_sig_a_q  <= s1_sig_a_d;
            s1_sig_b_q  <= s1_sig_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_rnd_q    <= s2_rnd_d;
            s2_cls_a_q  <= s2_cls_a_d;
            s2_cls_b_q  <= s2_cls_b_d;
            s2_exp_q    <= s2_exp_d;
            s2_prod_q   <= s2_prod_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised IEEE-754 binary floating-point multiplier: 3-stage pipeline with valid/ready handshake on both sides.
- Successor to the fixed single-precision two-stage multiplier. Adds:
  - generic exponent/mantissa width;
  - backpressure;
  - round-to-nearest-even;
  - special-value handling (zero, inf, NaN, subnormals);
  - per-result exception flags.
- Sits in the datapath between operand-fetch and result writeback FIFOs.

Parameters:
- EXP_W, 8: exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width; significand is MAN_W+1 bits.
- W = 1+EXP_W+MAN_W (localparam): operand/result width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- a  in  W  multiplicand
- b  in  W  multiplier
- rnd_mode  in  1  0 = truncate toward zero, 1 = round-nearest-even; captured with operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  W  product
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. All stage valid bits, result and flags reset to 0.
- Handshake:
  - adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - Transfer on in_valid && in_ready.
  - All stages shift together when adv = 1 and hold otherwise.
  - Bubbles propagate as valid = 0.
  - result/flags are stable while out_valid && !out_ready.
- Latency: exactly 3 cycles from accepted input to out_valid with no stall. Throughput: 1 per cycle. Results stay in order.
- Stage 1, unpack/classify:
  - sign = sa^sb.
  - Classes: exp==0 → ZERO (subnormals flushed, sign kept); exp all-ones with frac==0 → INF; exp all-ones with frac!=0 → NAN; otherwise NORM with hidden 1.
  - Exponent sum e = ea+eb-BIAS, held as a signed EXP_W+2-bit value.
- Stage 2: (MAN_W+1)x(MAN_W+1) unsigned multiply giving a 2*MAN_W+2-bit product.
- Stage 3, normalise/round/pack:
  - If product MSB = 1: use the top bits and set e += 1.
  - Guard G = first dropped bit; sticky S = OR of the remaining dropped bits.
  - RNE increments when G && (S || LSB). Truncate never increments.
  - A carry out of rounding gives frac = 0 and e += 1.
- Exponent range:
  - Overflow (e >= 2^EXP_W-1): RNE gives ±inf; truncate gives ±max finite. Sets overflow and inexact.
  - Underflow (e <= 0): flush to signed zero. Sets underflow and inexact.
  - Otherwise inexact = G|S.
- Special values (priority order):
  1. Any NAN, or INF×ZERO → canonical qNaN {0, all-ones, 1, 0...}. invalid=1 only for INF×ZERO.
  2. Any INF → signed inf, no flags.
  3. Any ZERO → signed zero, no flags.
- Reset mid-operation: all in-flight results are discarded. No out_valid until new input arrives.

Decomposition:
- Package fp_mul_pkg holds:
  - class enum fp_class_e {FP_ZERO, FP_NORM, FP_INF, FP_NAN};
  - flag bit index constants;
  - functions canon_nan(EXP_W, MAN_W) and max_finite.
- One sub-module fp_mul_norm_round: combinational stage-3 logic (normalise, round, range check, pack).
- fp_mul_pipe owns the registers and handshake.

Test Plan:
- Default params, RNE: 0x3FC00000 × 0x40000000 → 0x40400000, flags 0, out_valid exactly 3 cycles after acceptance.
- Rounding: 0x3F800001 × 0x3FC00000. RNE → 0x3FC00002, inexact=1. Truncate → 0x3FC00001, inexact=1.
- Range:
  - 0x7F000000 × 0x40000000: RNE → 0x7F800000 with overflow+inexact; truncate → 0x7F7FFFFF.
  - 0x00800000 × 0x00800000 → 0x00000000 with underflow+inexact.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0xFF800000 × 0x40000000 → 0xFF800000, no flags.
  - 0x80000000 × 0x3F800000 → 0x80000000.
- Backpressure: stream 6 back-to-back pairs, hold out_ready=0 for 5 cycles mid-stream. Checks:
  - in_ready drops;
  - no loss or duplication, order preserved;
  - result held stable during the stall.
  - Also assert rst_n mid-stream → out_valid=0 next cycle.
- EXP_W=5, MAN_W=10: 0x3C00 × 0x4000 → 0x4000; 0x7BFF × 0x4000 (RNE) → 0x7C00 with overflow+inexact.
